// File: rtl/bitserial_subtractor.sv
// bitserial_subtractor: LSB-first bit-serial a - b - bin with start/busy/done handshake.
// Per-bit stage is a 3-to-8 minterm decoder feeding OR gates, like the adder cells.
module bitserial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_res;
    logic             r_bw;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       w_m;
    logic             w_d, w_bo;
    logic [WIDTH-1:0] w_res;
    always_comb begin
        w_m   = 8'b1 << {r_a[0], r_b[0], r_bw};
        w_d   = w_m[1] | w_m[2] | w_m[4] | w_m[7];
        w_bo  = w_m[1] | w_m[2] | w_m[3] | w_m[7];
        w_res = {w_d, r_res[WIDTH-1:1]};
    end
    // diff/bout only change on the final bit, so an aborted or ignored op never disturbs them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_bw    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                SHIFT: begin
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_res <= w_res;
                    r_bw  <= w_bo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        diff    <= w_res;
                        bout    <= w_bo;
                    end
                end
                default: begin
                    if (start) begin
                        r_state <= SHIFT;
                        r_a     <= a;
                        r_b     <= b;
                        r_bw    <= bin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/bitserial_subtractor.md
# bitserial_subtractor

Sequential bit-serial full subtractor: computes `diff = a - b - bin` over `WIDTH` data bits, LSB first, one bit per clock. It complements the decoder-based adder cells by providing the reverse arithmetic direction. The combinational per-bit stage is a 3-to-8 decoder followed by OR gates, the same style as the adder cells. It sits beside the adders in the arithmetic datapath and trades latency for a single-bit datapath, using a start/busy/done handshake.

## Interface
- `WIDTH`, default 8: operand and result width in bits (≥2).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: request; sampled on a rising edge when accepting (IDLE or DONE).
- `a` input WIDTH: minuend; sampled with `start`.
- `b` input WIDTH: subtrahend; sampled with `start`.
- `bin` input 1: borrow-in; sampled with `start`.
- `busy` output 1: high while bits are being processed (SHIFT state).
- `done` output 1: one-cycle pulse; `diff`/`bout` newly valid.
- `diff` output WIDTH: registered result of the last completed operation.
- `bout` output 1: registered borrow-out of the last completed operation; 1 means `a < b + bin`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Transitions:
  - IDLE → SHIFT when `start`=1.
  - SHIFT → SHIFT while the bit counter is < WIDTH-1.
  - SHIFT → DONE on the edge processing bit WIDTH-1.
  - DONE → SHIFT if `start`=1, otherwise DONE → IDLE.
- On accept:
  - Load `a` and `b` into internal shift registers.
  - Load the borrow register with `bin`.
  - Clear the counter.
- Each SHIFT cycle, with x = a-reg[0], y = b-reg[0], w = borrow register:
  - Decode {x,y,w} into minterms m0..m7 (x is MSB).
  - Difference bit = m1|m2|m4|m7.
  - Next borrow = m1|m2|m3|m7.
  - Shift both operand registers right by one.
  - Shift the difference bit into the MSB of the internal result register.
  - Update the borrow register and increment the counter.
- On the SHIFT→DONE edge:
  - Copy the completed result to `diff`.
  - Copy the final borrow to `bout`.
- `diff`/`bout` hold their value until the next completion. An operation in progress never disturbs them.
- `start` during SHIFT is ignored: no restart, no queuing, and operand changes have no effect.
- Arithmetic is modulo 2^WIDTH. `diff` = (a - b - bin) mod 2^WIDTH and `bout` = (a < b + bin), with b + bin evaluated at WIDTH+1 bits.
- Reset (any time, including mid-SHIFT):
  - State goes to IDLE; `busy`=0, `done`=0, `diff`=0, `bout`=0.
  - Internal registers are cleared.
  - An aborted operation produces no `done`.

## Timing
- Accept edge E0 (start=1 in IDLE or DONE).
- `busy`=1 in the cycles after edges E0 .. E0+WIDTH-1, i.e. exactly WIDTH cycles.
- After edge E0+WIDTH: state DONE, `done`=1 for exactly one cycle, `busy`=0, and `diff`/`bout` updated.
- Latency from the start edge to valid result is WIDTH+1 edges.
- Back-to-back: if `start`=1 during DONE, the next operation is accepted at edge E0+WIDTH+1. Throughput is one result per WIDTH+1 cycles, and `busy` rises in the same cycle `done` falls.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset deassertion: the first accept is possible on the first rising edge after `rst` falls.

## Test plan
- WIDTH=8, a=0x05, b=0x03, bin=0, start pulsed one cycle:
  - `busy` high for 8 cycles.
  - `done` pulses on the 9th edge.
  - diff=0x02, bout=0.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1.
- a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- a=0xFF, b=0x00, bin=0 → diff=0xFF, bout=0.
- Start held high, then a second start pulse mid-SHIFT with different operands:
  - The second pulse is ignored.
  - The first result is delivered on schedule.
  - With start held during DONE, the next operation starts immediately with `busy` rising as `done` falls.
- Reset mid-operation, after 4 SHIFT cycles:
  - Outputs go to 0 immediately (asynchronously).
  - No `done` appears.
  - The next op a=0x80, b=0x01, bin=0 yields diff=0x7F, bout=0.
- Randomized follow-up: 1000 random {a,b,bin} compared against the reference arithmetic model.
